cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Centralised scheduler for the two common data buses (cdb[0], cdb[1]).
- Up to NUM_REQ requesters (ROB, ALUs, mult/div, load/store, branch) raise a level request. Each cycle the arbiter grants at most one requester per bus and drives the bus select address that each requester's local arbiter compares against its ADDRESS parameter.
- Round-robin among normal requesters; a parameter mask marks fixed-priority requesters (ROB).

Parameters:
- NUM_REQ, 8: number of requesters, at most 16.
- ADDR_W, 8: width of select address.
- REQ_ADDR, {8'h00..8'h07}: per-requester select address, index i maps to REQ_ADDR[i]; values must be unique and nonzero except index 0.
- PRIO_MASK, 8'b0000_0001: requesters served before the round-robin pool, lowest index first.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request; held until grant is seen.
- bus_en  in  2  bus b may be granted this cycle; low while bus is externally owned.
- flush  in  1  delete_tagged in progress; suppresses all new grants.
- grant  out  NUM_REQ  one-cycle grant pulse, registered.
- grant_bus  out  NUM_REQ  bus index for each asserted grant bit; 0 when grant low.
- select  out  2 x ADDR_W  REQ_ADDR of the bus owner; 0 when idle.
- select_valid  out  2  select[b] is meaningful.

Behaviour:
- Reset, asynchronous on posedge reset:
  - grant, grant_bus, select and select_valid all 0.
  - Round-robin pointer rr_ptr = 0.
  - Last-grant mask = 0.
- Latency: req sampled at edge n produces grant/select at edge n+1, visible for exactly one cycle. The requester drives the bus in that cycle.
- Eligibility: req[i] && !last_grant[i]. A requester granted in cycle n is ineligible for cycle n+1, which prevents a double grant while it drops req.
- Allocation order:
  - Bus 0 is filled first, then bus 1.
  - Disabled buses (bus_en[b]=0) are skipped. If only bus 1 is enabled, the first winner goes to bus 1.
- Winner selection:
  - First, eligible PRIO_MASK requesters in ascending index.
  - Then the round-robin pool: first eligible non-priority index at or after rr_ptr, wrapping modulo NUM_REQ. The second winner continues searching after the first.
- No requester is granted both buses in one cycle.
- rr_ptr update: advances to (highest-order round-robin winner index + 1) mod NUM_REQ only when at least one round-robin grant is issued. Priority-only grants leave it unchanged.
- flush=1: next-cycle grant, select_valid = 0 and rr_ptr is held. Requests stay pending and are re-arbitrated after flush drops.
- No eligible request: outputs idle, rr_ptr held.
- Fewer eligible requesters than enabled buses: unused bus idle (select=0, select_valid=0).
- Reset mid-grant: outputs clear immediately (asynchronous). Pending req is re-arbitrated from rr_ptr=0 after reset deasserts.
- Invariants:
  - popcount(grant) ≤ popcount(bus_en sampled).
  - select[0] != select[1] whenever both valid.
  - Starvation bound for a non-priority requester with no priority traffic: at most ceil((NUM_REQ-1)/2)+1 cycles.

Decomposition:
- cdb_pkg:
  - NUM_CDB = 2
  - cdb_addr_t (logic [ADDR_W-1:0])
  - cdb_select_t struct {addr, valid}
  - CDB_IDLE_ADDR = '0
- Sub-module rr_pick: combinational find-first-set from a start index with wrap.
  - Ports: vector in, start in, found out, index out.
  - Instantiated twice: second instance uses first winner masked out and start = winner+1.
- Priority pick is a plain find-first-set, shared in rr_pick with start=0.

Test Plan:
- Reset then req=8'b0000_0110, bus_en=2'b11 → next cycle:
  - grant=8'b0000_0110
  - select[0]=8'h01, select[1]=8'h02, both valid
  - rr_ptr=3
- req=8'hFE held high for 8 cycles, PRIO_MASK default → grants rotate pairs {1,2},{3,4},{5,6},{7,1}…, never the same index in consecutive cycles.
- req=8'b1000_0001 with bus_en=2'b10 → ROB (index 0) granted on bus 1, select[1]=8'h00 valid, select_valid[0]=0. Index 7 granted the following cycle.
- flush=1 for 3 cycles with req=8'h0C → no grants during flush. First cycle after flush drops grants {2,3}.
- Assert reset while grant=8'h02 mid-cycle → grant, select_valid drop to 0 before the next clk edge. After release with req=8'h02, grant reappears 1 cycle later.
- Single requester 5 holding req continuously → grant[5] pulses every other cycle (1,0,1,0), always on bus 0, select[0]=8'h05.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
package cdb_pkg;

  localparam int NUM_CDB    = 2;
  localparam int CDB_ADDR_W = 8;

  typedef logic [CDB_ADDR_W-1:0] cdb_addr_t;

  typedef struct packed {
    cdb_addr_t addr;
    logic      valid;
  } cdb_select_t;

  localparam cdb_addr_t CDB_IDLE_ADDR = '0;

  // Index of the slot after idx in a ring of n slots.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational find-first-set starting at an arbitrary index, wrapping around.
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vector,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] pos;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(start) + k) % N);
      if (!found && vector[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants up to one requester per common data bus each cycle: priority set first, then round-robin.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int                               NUM_REQ   = 8,
  parameter int                               ADDR_W    = CDB_ADDR_W,
  parameter logic [NUM_REQ-1:0][ADDR_W-1:0]   REQ_ADDR  = {8'h07, 8'h06, 8'h05, 8'h04,
                                                           8'h03, 8'h02, 8'h01, 8'h00},
  parameter logic [NUM_REQ-1:0]               PRIO_MASK = 8'b0000_0001
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_CDB-1:0]               bus_en,
  input  logic                             flush,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               grant_bus,
  output logic [NUM_CDB-1:0][ADDR_W-1:0]   select,
  output logic [NUM_CDB-1:0]               select_valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d, r1_start;
  logic [NUM_REQ-1:0] elig, prio_vec, rr_vec, p0_mask, r0_mask;
  logic               p0_found, p1_found, r0_found, r1_found;
  logic [IDX_W-1:0]   p0_idx, p1_idx, r0_idx, r1_idx;
  logic               w0_found, w1_found, w0_rr, w1_rr, use_w0, use_w1, b0;
  logic [IDX_W-1:0]   w0_idx, w1_idx;
  logic [NUM_REQ-1:0] grant_d, grant_bus_d;
  cdb_select_t        sel_q [NUM_CDB];
  cdb_select_t        sel_d [NUM_CDB];

  // The registered grant doubles as the last-grant mask that blocks back-to-back wins.
  assign elig     = req & ~grant;
  assign prio_vec = elig & PRIO_MASK;
  assign rr_vec   = elig & ~PRIO_MASK;
  assign p0_mask  = p0_found ? (NUM_REQ'(1) << p0_idx) : '0;
  assign r0_mask  = r0_found ? (NUM_REQ'(1) << r0_idx) : '0;
  assign r1_start = IDX_W'(wrap_inc(32'(r0_idx), NUM_REQ));

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_prio0 (
    .vector(prio_vec), .start('0), .found(p0_found), .index(p0_idx));
  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_prio1 (
    .vector(prio_vec & ~p0_mask), .start('0), .found(p1_found), .index(p1_idx));
  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_rr0 (
    .vector(rr_vec), .start(rr_ptr), .found(r0_found), .index(r0_idx));
  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_rr1 (
    .vector(rr_vec & ~r0_mask), .start(r1_start), .found(r1_found), .index(r1_idx));

  // Winner list in allocation order: priority picks first, round-robin fills the rest.
  always_comb begin
    w0_found = p0_found | r0_found;
    w0_idx   = p0_found ? p0_idx : r0_idx;
    w0_rr    = !p0_found;
    if (p0_found) begin
      w1_found = p1_found | r0_found;
      w1_idx   = p1_found ? p1_idx : r0_idx;
      w1_rr    = !p1_found;
    end else begin
      w1_found = r1_found;
      w1_idx   = r1_idx;
      w1_rr    = 1'b1;
    end
  end

  always_comb begin
    grant_d     = '0;
    grant_bus_d = '0;
    rr_ptr_d    = rr_ptr;
    for (int b = 0; b < NUM_CDB; b++) sel_d[b] = '{addr: CDB_IDLE_ADDR, valid: 1'b0};
    use_w0 = !flush && w0_found && (|bus_en);
    use_w1 = !flush && w1_found && (&bus_en);
    b0     = !bus_en[0];
    if (use_w0) begin
      grant_d[w0_idx]     = 1'b1;
      grant_bus_d[w0_idx] = b0;
      sel_d[b0]           = '{addr: cdb_addr_t'(REQ_ADDR[w0_idx]), valid: 1'b1};
      if (w0_rr) rr_ptr_d = IDX_W'(wrap_inc(32'(w0_idx), NUM_REQ));
    end
    // The second winner is later in search order, so its pointer update takes precedence.
    if (use_w1) begin
      grant_d[w1_idx]     = 1'b1;
      grant_bus_d[w1_idx] = 1'b1;
      sel_d[1]            = '{addr: cdb_addr_t'(REQ_ADDR[w1_idx]), valid: 1'b1};
      if (w1_rr) rr_ptr_d = IDX_W'(wrap_inc(32'(w1_idx), NUM_REQ));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      grant_bus <= '0;
      rr_ptr    <= '0;
      for (int b = 0; b < NUM_CDB; b++) sel_q[b] <= '{addr: CDB_IDLE_ADDR, valid: 1'b0};
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      grant     <= grant_d;
      grant_bus <= grant_bus_d;
      rr_ptr    <= rr_ptr_d;
      for (int b = 0; b < NUM_CDB; b++) sel_q[b] <= sel_d[b];
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_CDB; b++) begin
      select[b]       = ADDR_W'(sel_q[b].addr);
      select_valid[b] = sel_q[b].valid;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: driver queues expected outputs, monitor compares on negedge.
module tb_cdb_arbiter;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      req;
  logic [1:0]      bus_en;
  logic            flush;
  logic [7:0]      grant, grant_bus;
  logic [1:0][7:0] select;
  logic [1:0]      select_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [7:0] grant, gbus, s0, s1;
    logic [1:0] sv;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    logic [1:0] be;
    logic       fl;
    logic [7:0] grant, gbus, s0, s1;
    logic [1:0] sv;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .bus_en(bus_en), .flush(flush),
    .grant(grant), .grant_bus(grant_bus), .select(select), .select_valid(select_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  // Apply inputs now; they are sampled at the next posedge, whose outputs are queued as expected.
  task automatic apply(input vec_t v);
    exp_t e;
    req = v.req; bus_en = v.be; flush = v.fl;
    e.cyc = cyc + 1; e.grant = v.grant; e.gbus = v.gbus;
    e.s0 = v.s0; e.s1 = v.s1; e.sv = v.sv;
    exp_q.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk); #2;
    apply(v);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      check("grant",        32'(grant),        32'(mon_e.grant));
      check("grant_bus",    32'(grant_bus),    32'(mon_e.gbus));
      check("select0",      32'(select[0]),    32'(mon_e.s0));
      check("select1",      32'(select[1]),    32'(mon_e.s1));
      check("select_valid", 32'(select_valid), 32'(mon_e.sv));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam vec_t IDLE = '{8'h00, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00};

  vec_t vecs[] = '{
    // two round-robin winners from rr_ptr=0, pointer moves to 3
    '{8'h06, 2'b11, 1'b0, 8'h06, 8'h04, 8'h01, 8'h02, 2'b11},
    IDLE,
    // bus 0 only: search from 3 picks 3 ahead of 1
    '{8'h0A, 2'b01, 1'b0, 8'h08, 8'h00, 8'h03, 8'h00, 2'b01},
    IDLE,
    // 8 cycles of 8'hFE from rr_ptr=4
    '{8'hFE, 2'b11, 1'b0, 8'h30, 8'h20, 8'h04, 8'h05, 2'b11},
    '{8'hFE, 2'b11, 1'b0, 8'hC0, 8'h80, 8'h06, 8'h07, 2'b11},
    '{8'hFE, 2'b11, 1'b0, 8'h06, 8'h04, 8'h01, 8'h02, 2'b11},
    '{8'hFE, 2'b11, 1'b0, 8'h18, 8'h10, 8'h03, 8'h04, 2'b11},
    '{8'hFE, 2'b11, 1'b0, 8'h60, 8'h40, 8'h05, 8'h06, 2'b11},
    '{8'hFE, 2'b11, 1'b0, 8'h82, 8'h02, 8'h07, 8'h01, 2'b11},
    '{8'hFE, 2'b11, 1'b0, 8'h0C, 8'h08, 8'h02, 8'h03, 2'b11},
    '{8'hFE, 2'b11, 1'b0, 8'h30, 8'h20, 8'h04, 8'h05, 2'b11},
    IDLE,
    // only bus 1 enabled: ROB first, then index 7
    '{8'h81, 2'b10, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 2'b10},
    '{8'h81, 2'b10, 1'b0, 8'h80, 8'h80, 8'h00, 8'h07, 2'b10},
    IDLE,
    // flush holds everything off, then {2,3} from rr_ptr=0
    '{8'h0C, 2'b11, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00},
    '{8'h0C, 2'b11, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00},
    '{8'h0C, 2'b11, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00},
    '{8'h0C, 2'b11, 1'b0, 8'h0C, 8'h08, 8'h02, 8'h03, 2'b11},
    IDLE,
    // priority plus round-robin in one cycle
    '{8'h21, 2'b11, 1'b0, 8'h21, 8'h20, 8'h00, 8'h05, 2'b11},
    IDLE,
    // no buses enabled, then a single bus goes to the priority requester
    '{8'h21, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00},
    '{8'h21, 2'b01, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 2'b01},
    IDLE,
    // lone requester 5 held high: grants every other cycle
    '{8'h20, 2'b11, 1'b0, 8'h20, 8'h00, 8'h05, 8'h00, 2'b01},
    '{8'h20, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00},
    '{8'h20, 2'b11, 1'b0, 8'h20, 8'h00, 8'h05, 8'h00, 2'b01},
    '{8'h20, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00},
    IDLE
  };

  initial begin
    reset = 1'b1; req = '0; bus_en = 2'b00; flush = 1'b0;
    #1;
    check("reset_grant",     32'(grant),        32'h0);
    check("reset_grant_bus", 32'(grant_bus),    32'h0);
    check("reset_select",    32'(select),       32'h0);
    check("reset_valid",     32'(select_valid), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    foreach (vecs[i]) drive(vecs[i]);

    // Reset lands while grant is visible; the queued entry for that cycle is the cleared state.
    drive('{8'h02, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00});
    @(posedge clk); #1;
    check("pre_reset_grant", 32'(grant), 32'h02);
    #1 reset = 1'b1;
    #1;
    check("async_reset_grant", 32'(grant),        32'h0);
    check("async_reset_valid", 32'(select_valid), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    apply('{8'h02, 2'b11, 1'b0, 8'h02, 8'h00, 8'h01, 8'h00, 2'b01});
    drive(IDLE);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
